rr_grant_fsm: RTL and testbench

- Moore-style round-robin arbiter FSM that shares one resource (e.g. a single toggle/state-machine datapath) between N requesters.
- Registered one-hot grant, rotating priority pointer, saturating grant counter, optional hold-timeout.
- Sits between requester FSMs and the shared resource; the resource sees only the winner's signals, muxed by `owner`.

---
 rtl/rr_grant_if.sv | 24 ++
 rtl/rr_grant_fsm.sv | 111 +++++++++++
 tb/tb_rr_grant_fsm.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_if.sv
// Request/grant bundle between requester FSMs and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_grant_if #(
   parameter int N    = 4,
   parameter int IDXW = 2
);
   logic [N-1:0]    req;
   logic            done;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] owner;
   logic            busy;
   logic [7:0]      grant_cnt;
   logic            timeout;

   modport master (
      output req, done,
      input  gnt, owner, busy, grant_cnt, timeout
   );

   modport slave (
      input  req, done,
      output gnt, owner, busy, grant_cnt, timeout
   );
endinterface

// File: rtl/rr_grant_fsm.sv
// Moore round-robin arbiter: registered one-hot grant, rotating pointer, saturating grant count.
// Define RR_GRANT_TIMEOUT_EN to compile in the MAX_HOLD forced-release timeout.
module rr_grant_fsm #(
   parameter int N        = 4,
   parameter int IDXW     = 2,
   parameter int MAX_HOLD = 8
) (
   input  logic      clk,
   input  logic      reset,
   rr_grant_if.slave bus
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   if (N < 1 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
      $error("rr_grant_fsm: N or MAX_HOLD out of range");
   end

   logic [0:0]      state;
   logic [N-1:0]    gnt_q;
   logic [IDXW-1:0] owner_q;
   logic [IDXW-1:0] ptr_q;
   logic [7:0]      cnt_q;
   logic            timeout_q;

   logic            found;
   logic [IDXW-1:0] win;
   logic            rel_norm;
   logic            force_rel;
   int              idx;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Wrap by compare so non-power-of-two N never lands on an unused index.
   function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] v);
      if (v == IDXW'(N - 1)) return '0;
      return v + 1'b1;
   endfunction

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!found && bus.req[IDXW'(idx)]) begin
            found = 1'b1;
            win   = IDXW'(idx);
         end
      end
   end

   assign rel_norm = bus.done || !bus.req[owner_q];

`ifdef RR_GRANT_TIMEOUT_EN
   logic [7:0] hold_q;

   // Held at zero in IDLE so the count starts fresh on every grant.
   always_ff @(posedge clk) begin
      if (reset || state == IDLE) hold_q <= 8'd0;
      else                        hold_q <= hold_q + 8'd1;
   end

   assign force_rel = (state == GRANT) && (hold_q == 8'(MAX_HOLD - 1)) && !rel_norm;
`else
   assign force_rel = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state   <= GRANT;
                  owner_q <= win;
                  gnt_q   <= N'(1) << win;
                  cnt_q   <= sat_inc8(cnt_q);
               end
            end
            GRANT: begin
               if (rel_norm || force_rel) begin
                  state     <= IDLE;
                  gnt_q     <= '0;
                  ptr_q     <= wrap_inc(owner_q);
                  timeout_q <= force_rel;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.owner     = owner_q;
   assign bus.busy      = (state == GRANT);
   assign bus.grant_cnt = cnt_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed bench for rr_grant_fsm: N=4 instance for most scenarios, N=3 instance for wrap cases.
module tb_rr_grant_fsm;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   rr_grant_if #(.N(4), .IDXW(2)) b4 ();
   rr_grant_if #(.N(3), .IDXW(2)) b3 ();

   rr_grant_fsm #(.N(4), .IDXW(2), .MAX_HOLD(8)) dut4 (.clk(clk), .reset(reset), .bus(b4));
   rr_grant_fsm #(.N(3), .IDXW(2), .MAX_HOLD(8)) dut3 (.clk(clk), .reset(reset), .bus(b3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      b4.req = '0; b4.done = 1'b0;
      b3.req = '0; b3.done = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy, b4.grant_cnt, b4.timeout} !== 16'h0000) begin
         errs++;
         $display("FAIL reset_idle: got %h want 0000", {b4.gnt, b4.owner, b4.busy, b4.grant_cnt, b4.timeout});
      end
      b4.req = 4'b0100;
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy, b4.grant_cnt} !== {4'b0100, 2'd2, 1'b1, 8'd1}) begin
         errs++;
         $display("FAIL reset_pre_grant: got %h want %h", {b4.gnt, b4.owner, b4.busy, b4.grant_cnt}, {4'b0100, 2'd2, 1'b1, 8'd1});
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b4.req = '0;
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy, b4.grant_cnt, b4.timeout} !== 16'h0000) begin
         errs++;
         $display("FAIL reset_mid_grant: got %h want 0000", {b4.gnt, b4.owner, b4.busy, b4.grant_cnt, b4.timeout});
      end
   endtask

   task automatic test_latency();
      do_reset();
      b4.req = 4'b0100;
      #1;
      vecs++;
      if ({b4.gnt, b4.busy} !== 5'b0) begin
         errs++;
         $display("FAIL latency_no_comb: got %b want 00000", {b4.gnt, b4.busy});
      end
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy} !== {4'b0100, 2'd2, 1'b1}) begin
         errs++;
         $display("FAIL latency_grant: got %b want %b", {b4.gnt, b4.owner, b4.busy}, {4'b0100, 2'd2, 1'b1});
      end
      b4.req = 4'b0111;
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy} !== {4'b0100, 2'd2, 1'b1}) begin
         errs++;
         $display("FAIL latency_no_preempt: got %b want %b", {b4.gnt, b4.owner, b4.busy}, {4'b0100, 2'd2, 1'b1});
      end
      tick();
      b4.done = 1'b1;
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy} !== {4'b0000, 2'd2, 1'b0}) begin
         errs++;
         $display("FAIL latency_release: got %b want %b", {b4.gnt, b4.owner, b4.busy}, {4'b0000, 2'd2, 1'b0});
      end
      b4.done = 1'b0;
      b4.req  = '0;
   endtask

   task automatic test_rotation();
      logic [3:0] eg;
      logic [1:0] eo;
      do_reset();
      b4.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         eg = 4'b0001 << (k % 4);
         eo = 2'(k % 4);
         tick();
         vecs++;
         if ({b4.gnt, b4.owner, b4.busy} !== {eg, eo, 1'b1}) begin
            errs++;
            $display("FAIL rotation_grant%0d: got %b want %b", k, {b4.gnt, b4.owner, b4.busy}, {eg, eo, 1'b1});
         end
         tick();
         b4.done = 1'b1;
         tick();
         b4.done = 1'b0;
         vecs++;
         if ({b4.gnt, b4.busy} !== 5'b0) begin
            errs++;
            $display("FAIL rotation_gap%0d: got %b want 00000", k, {b4.gnt, b4.busy});
         end
      end
      vecs++;
      if (b4.grant_cnt !== 8'd5) begin
         errs++;
         $display("FAIL rotation_count: got %0d want 5", b4.grant_cnt);
      end
      tick();
      vecs++;
      if ({b4.gnt, b4.owner} !== {4'b0010, 2'd1}) begin
         errs++;
         $display("FAIL rotation_ptr: got %b want %b", {b4.gnt, b4.owner}, {4'b0010, 2'd1});
      end
   endtask

   task automatic test_req_drop();
      do_reset();
      b4.req = 4'b0010;
      tick();
      b4.req = 4'b1010;
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy} !== {4'b0010, 2'd1, 1'b1}) begin
         errs++;
         $display("FAIL drop_hold: got %b want %b", {b4.gnt, b4.owner, b4.busy}, {4'b0010, 2'd1, 1'b1});
      end
      b4.req = 4'b1000;
      tick();
      vecs++;
      if ({b4.gnt, b4.busy} !== 5'b0) begin
         errs++;
         $display("FAIL drop_release: got %b want 00000", {b4.gnt, b4.busy});
      end
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy, b4.grant_cnt} !== {4'b1000, 2'd3, 1'b1, 8'd2}) begin
         errs++;
         $display("FAIL drop_next: got %h want %h", {b4.gnt, b4.owner, b4.busy, b4.grant_cnt}, {4'b1000, 2'd3, 1'b1, 8'd2});
      end
      b4.req  = '0;
      b4.done = 1'b1;
      tick();
      b4.done = 1'b0;
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy, b4.grant_cnt} !== {4'b0000, 2'd3, 1'b0, 8'd2}) begin
         errs++;
         $display("FAIL drop_dual_release: got %h want %h", {b4.gnt, b4.owner, b4.busy, b4.grant_cnt}, {4'b0000, 2'd3, 1'b0, 8'd2});
      end
      tick();
      vecs++;
      if ({b4.busy, b4.grant_cnt} !== {1'b0, 8'd2}) begin
         errs++;
         $display("FAIL drop_settle: got %h want %h", {b4.busy, b4.grant_cnt}, {1'b0, 8'd2});
      end
   endtask

   task automatic test_wrap_n3();
      do_reset();
      b3.req = 3'b100;
      tick();
      vecs++;
      if ({b3.gnt, b3.owner} !== {3'b100, 2'd2}) begin
         errs++;
         $display("FAIL wrap_first: got %b want %b", {b3.gnt, b3.owner}, {3'b100, 2'd2});
      end
      b3.req  = 3'b101;
      b3.done = 1'b1;
      tick();
      b3.done = 1'b0;
      vecs++;
      if ({b3.gnt, b3.busy} !== 4'b0) begin
         errs++;
         $display("FAIL wrap_release: got %b want 0000", {b3.gnt, b3.busy});
      end
      tick();
      vecs++;
      if ({b3.gnt, b3.owner} !== {3'b001, 2'd0}) begin
         errs++;
         $display("FAIL wrap_to_zero: got %b want %b", {b3.gnt, b3.owner}, {3'b001, 2'd0});
      end
      b3.req = 3'b010;
      tick();
      tick();
      vecs++;
      if ({b3.gnt, b3.owner} !== {3'b010, 2'd1}) begin
         errs++;
         $display("FAIL wrap_owner1: got %b want %b", {b3.gnt, b3.owner}, {3'b010, 2'd1});
      end
      b3.done = 1'b1;
      tick();
      b3.done = 1'b0;
      vecs++;
      if ({b3.gnt, b3.busy} !== 4'b0) begin
         errs++;
         $display("FAIL wrap_regrant_gap: got %b want 0000", {b3.gnt, b3.busy});
      end
      tick();
      vecs++;
      if ({b3.gnt, b3.owner, b3.busy, b3.grant_cnt} !== {3'b010, 2'd1, 1'b1, 8'd4}) begin
         errs++;
         $display("FAIL wrap_regrant: got %h want %h", {b3.gnt, b3.owner, b3.busy, b3.grant_cnt}, {3'b010, 2'd1, 1'b1, 8'd4});
      end
   endtask

   task automatic test_timeout();
      do_reset();
      b4.req = 4'b0001;
      tick();
      vecs++;
      if ({b4.gnt, b4.busy, b4.timeout} !== {4'b0001, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL hold_start: got %b want %b", {b4.gnt, b4.busy, b4.timeout}, {4'b0001, 1'b1, 1'b0});
      end
`ifdef RR_GRANT_TIMEOUT_EN
      b4.req = 4'b0011;
      for (int c = 1; c < 8; c++) begin
         tick();
         vecs++;
         if ({b4.gnt, b4.busy, b4.timeout} !== {4'b0001, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL hold_cycle%0d: got %b want %b", c, {b4.gnt, b4.busy, b4.timeout}, {4'b0001, 1'b1, 1'b0});
         end
      end
      tick();
      vecs++;
      if ({b4.gnt, b4.busy, b4.timeout} !== {4'b0000, 1'b0, 1'b1}) begin
         errs++;
         $display("FAIL timeout_pulse: got %b want %b", {b4.gnt, b4.busy, b4.timeout}, {4'b0000, 1'b0, 1'b1});
      end
      tick();
      vecs++;
      if ({b4.gnt, b4.owner, b4.busy, b4.timeout} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL timeout_next: got %b want %b", {b4.gnt, b4.owner, b4.busy, b4.timeout}, {4'b0010, 2'd1, 1'b1, 1'b0});
      end
      for (int c = 0; c < 7; c++) tick();
      b4.done = 1'b1;
      tick();
      b4.done = 1'b0;
      vecs++;
      if ({b4.gnt, b4.busy, b4.timeout} !== 6'b0) begin
         errs++;
         $display("FAIL timeout_normal_wins: got %b want 000000", {b4.gnt, b4.busy, b4.timeout});
      end
`else
      begin : no_timeout
         int bad;
         bad = 0;
         for (int c = 0; c < 110; c++) begin
            tick();
            if (b4.gnt !== 4'b0001 || b4.timeout !== 1'b0) bad++;
         end
         vecs++;
         if (bad != 0) begin
            errs++;
            $display("FAIL hold_forever: got %0d bad cycles want 0", bad);
         end
         vecs++;
         if ({b4.owner, b4.busy, b4.grant_cnt} !== {2'd0, 1'b1, 8'd1}) begin
            errs++;
            $display("FAIL hold_forever_state: got %h want %h", {b4.owner, b4.busy, b4.grant_cnt}, {2'd0, 1'b1, 8'd1});
         end
      end
`endif
      b4.req = '0;
   endtask

   initial begin
      b4.req = '0; b4.done = 1'b0;
      b3.req = '0; b3.done = 1'b0;
      test_reset();
      test_latency();
      test_rotation();
      test_req_drop();
      test_wrap_n3();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
